// File: rtl/hazard_stall_ctl_if.sv
// Pipeline-side hazard fields in, stage enable/hold controls and perf counters out.
// master = pipeline driving hazard sources; slave = stall controller.
interface hazard_stall_ctl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [2:0]       ex_rd;
    logic             ex_memtoreg;
    logic             ex_regwrite;
    logic             br_taken;
    logic             imem_stall;
    logic             dmem_stall;
    logic             dmem_done;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_hold;
    logic             exmem_hold;
    logic             memwb_hold;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_memtoreg, ex_regwrite,
               br_taken, imem_stall, dmem_stall, dmem_done, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_hold, exmem_hold, memwb_hold,
               halted, mem_timeout, stall_cnt, bubble_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_memtoreg, ex_regwrite,
               br_taken, imem_stall, dmem_stall, dmem_done, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_hold, exmem_hold, memwb_hold,
               halted, mem_timeout, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/hazard_stall_ctl.sv
// Stall/flush controller: Mealy stage controls from load-use, branch, I/D-cache miss and halt.
// Whole pipe freezes while the D-cache misses; saturating stall/bubble counters and a sticky wait timeout.
module hazard_stall_ctl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctl_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_q;
    logic               mem_timeout_q;

    logic               load_use;
    logic               freeze;
    logic               halt_now;
    logic               bubble_inc;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_en;
    logic               hold;
    logic               halted;

    always_comb begin
        load_use = bus.ex_memtoreg & bus.ex_regwrite &
                   ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                    (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
        // The completing cycle is not frozen, so a miss of N busy cycles costs exactly N.
        freeze   = (state != HALTED) && !bus.dmem_done &&
                   ((state == MEM_WAIT) || bus.dmem_stall);
        halt_now = (state == HALTED) || (bus.wb_halt && !freeze);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (halt_now)
                    state_nxt = HALTED;
                else if (bus.dmem_stall && !bus.dmem_done)
                    state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (halt_now)
                    state_nxt = HALTED;
                else if (bus.dmem_done)
                    state_nxt = RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        hold       = 1'b0;
        halted     = 1'b0;
        bubble_inc = 1'b0;
        if (rst) begin
            pc_en = 1'b0;
        end else if (halt_now) begin
            hold   = 1'b1;
            halted = 1'b1;
        end else if (freeze) begin
            // EX is held, so a pending br_taken survives and is serviced after the freeze.
            hold    = 1'b1;
            idex_en = 1'b1;
        end else if (bus.br_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
        end else if (load_use) begin
            bubble_inc = 1'b1;
        end else if (bus.imem_stall) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            wait_cnt      <= '0;
            stall_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (freeze && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}}))
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            if ((state != MEM_WAIT) && (state_nxt == MEM_WAIT))
                wait_cnt <= '0;
            else if ((state == MEM_WAIT) && (wait_cnt != WAIT_W'(TIMEOUT)))
                wait_cnt <= wait_cnt + 1'b1;
            if ((state == MEM_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT - 1)))
                mem_timeout_q <= 1'b1;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_hold   = hold;
    assign bus.exmem_hold  = hold;
    assign bus.memwb_hold  = hold;
    assign bus.halted      = halted;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule
